// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - capture side of a multiplexed 7-segment bus: debounce, decode, frame handshake
// Each stable one-hot digit dwell is decoded into a slot; a full set of slots is published as one frame.
module seg7_scan_decoder #(
  parameter int NDIG       = 8,
  parameter int STABLE_CYC = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [6:0]          seg,
  input  logic [NDIG-1:0]     an,
  output logic                frame_valid,
  input  logic                frame_ready,
  output logic [4*NDIG-1:0]   frame_data,
  output logic                frame_err,
  output logic                overrun
);

  localparam int          SW      = NDIG + 7;
  localparam logic [7:0]  CNT_MAX = 8'(STABLE_CYC);
  localparam logic [7:0]  CNT_CAP = 8'(STABLE_CYC - 1);

  logic [SW-1:0]     sample_q, prev_q;
  logic [7:0]        cnt_q, cnt_d;
  logic [NDIG-1:0]   seen_q, seen_d, ill_q, ill_d;
  logic [4*NDIG-1:0] slot_q, slot_d, data_q, data_d;
  logic              valid_q, valid_d, err_q, err_d, ovr_q, ovr_d;
  logic              capture, complete;
  logic [NDIG-1:0]   sel;
  logic [4:0]        dec;

  function automatic logic onehot(input logic [NDIG-1:0] v);
    return (v != '0) && ((v & (v - NDIG'(1))) == '0);
  endfunction

  // Result is {illegal, code}
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'b0000001: decode = 5'h00;
      7'b1001111: decode = 5'h01;
      7'b0010010: decode = 5'h02;
      7'b0000110: decode = 5'h03;
      7'b1001100: decode = 5'h04;
      7'b0100100: decode = 5'h05;
      7'b0100000: decode = 5'h06;
      7'b0001111: decode = 5'h07;
      7'b0000000: decode = 5'h08;
      7'b0000100: decode = 5'h09;
      7'b1111111: decode = 5'h0E;
      default:    decode = 5'h1F;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q <= '0;
      prev_q   <= '0;
      cnt_q    <= '0;
      seen_q   <= '0;
      ill_q    <= '0;
      slot_q   <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      sample_q <= {an, seg};
      prev_q   <= sample_q;
      cnt_q    <= cnt_d;
      seen_q   <= seen_d;
      ill_q    <= ill_d;
      slot_q   <= slot_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      ovr_q    <= ovr_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if ((sample_q != prev_q) || !onehot(~sample_q[SW-1:7])) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // prev_q holds the last of the counted equal samples when the count hits CNT_CAP
  assign sel     = ~prev_q[SW-1:7];
  assign dec     = decode(prev_q[6:0]);
  assign capture = (cnt_q == CNT_CAP) && onehot(sel);

  always_comb begin
    slot_d   = slot_q;
    ill_d    = ill_q;
    seen_d   = seen_q;
    complete = 1'b0;
    for (int k = 0; k < NDIG; k++) begin
      if (capture && sel[k]) begin
        slot_d[4*k +: 4] = dec[3:0];
        ill_d[k]         = dec[4];
        seen_d[k]        = 1'b1;
      end
    end
    complete = capture && (&seen_d);
    if (complete) begin
      seen_d = '0;
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    err_d   = err_q;
    ovr_d   = ovr_q;
    if (valid_q && frame_ready) begin
      valid_d = 1'b0;
    end
    if (complete) begin
      if (!valid_q || frame_ready) begin
        valid_d = 1'b1;
        data_d  = slot_d;
        err_d   = |ill_d;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  assign frame_valid = valid_q;
  assign frame_data  = data_q;
  assign frame_err   = err_q;
  assign overrun     = ovr_q;

endmodule
